// File: rtl/br_puf_challenger.sv
// ============================================================================
// Module   : br_puf_challenger
// Brief    : Challenge/response controller for a bistable-ring PUF macro.
//            Takes a challenge on a valid/ready port, pulses the ring reset,
//            waits for the synchronised ring output to settle (or time out),
//            samples it and returns a response bit plus a stability flag.
// Options  : BR_MAJORITY_EN - evaluate each challenge NEVAL times and return
//            the majority bit and the count of ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_puf_challenger #(
    parameter int CW         = 128,
    parameter int RST_CYC    = 8,
    parameter int STABLE_CYC = 16,
    parameter int SETTLE_MAX = 1024,
    parameter int NEVAL      = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ch_valid_i,
    output logic                       ch_ready_o,
    input  logic [CW-1:0]              ch_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       rsp_bit_o,
    output logic                       rsp_unstable_o,
    output logic [$clog2(NEVAL+1)-1:0] rsp_ones_o,
    output logic                       puf_reset_o,
    output logic [CW-1:0]              puf_c_o,
    input  logic                       puf_out_i,
    output logic                       busy_o
);

    // Counter widths; the reset counter needs at least one bit even for RST_CYC=1
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int EL_W = $clog2(SETTLE_MAX);
    localparam int ST_W = $clog2(STABLE_CYC + 1);
    localparam int OW   = $clog2(NEVAL + 1);

    localparam logic [RC_W-1:0] C_RST_LAST = RC_W'(RST_CYC - 1);
    localparam logic [EL_W-1:0] C_EL_LAST  = EL_W'(SETTLE_MAX - 1);
    localparam logic [ST_W-1:0] C_STABLE   = ST_W'(STABLE_CYC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic            prev_q;
    logic            synced;
    logic [RC_W-1:0] rst_cnt_q;
    logic [EL_W-1:0] elapsed_q;
    logic [ST_W-1:0] stable_q;
    logic [ST_W-1:0] stable_d;
    logic            unstab_q;
    logic [CW-1:0]   puf_c_q;
    logic            puf_reset_q;
    logic            ch_ready_q;
    logic            rsp_valid_q;
    logic            rsp_bit_q;
    logic            rsp_unstable_q;
    logic            busy_q;

`ifdef BR_MAJORITY_EN
    localparam logic [OW-1:0] C_NEVAL = OW'(NEVAL);
    localparam logic [OW-1:0] C_HALF  = OW'(NEVAL / 2);

    logic [OW-1:0] eval_q;
    logic [OW-1:0] eval_d;
    logic [OW-1:0] ones_q;
    logic [OW-1:0] ones_d;
    logic [OW-1:0] rsp_ones_q;
`endif

    // Only the second synchroniser stage is ever used by the controller
    assign synced = sync_q[1];

    // Two-flop synchroniser on the asynchronous ring output plus one sample of history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], puf_out_i};
            prev_q <= sync_q[1];
        end
    end

    // Next values of the stability run length and, in majority builds, the accumulators
    always_comb begin
        stable_d = '0;
        if (synced == prev_q) begin
            stable_d = stable_q + 1'b1;
        end
`ifdef BR_MAJORITY_EN
        ones_d = ones_q + OW'(synced);
        eval_d = eval_q + 1'b1;
`endif
    end

    // Evaluation sequencer: handshake, ring reset pulse, settle watch, sample, response hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            rst_cnt_q      <= '0;
            elapsed_q      <= '0;
            stable_q       <= '0;
            unstab_q       <= 1'b0;
            puf_c_q        <= '0;
            puf_reset_q    <= 1'b1;
            ch_ready_q     <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_bit_q      <= 1'b0;
            rsp_unstable_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef BR_MAJORITY_EN
            eval_q         <= '0;
            ones_q         <= '0;
            rsp_ones_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Ring stays parked in reset while no challenge is pending
                    ch_ready_q  <= 1'b1;
                    puf_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (ch_valid_i && ch_ready_q) begin
                        state_q    <= S_RST;
                        puf_c_q    <= ch_data_i;
                        ch_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        rst_cnt_q  <= '0;
                        unstab_q   <= 1'b0;
`ifdef BR_MAJORITY_EN
                        eval_q     <= '0;
                        ones_q     <= '0;
`endif
                    end
                end

                S_RST: begin
                    if (rst_cnt_q == C_RST_LAST) begin
                        state_q     <= S_SETTLE;
                        puf_reset_q <= 1'b0;
                        elapsed_q   <= '0;
                        stable_q    <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end

                S_SETTLE: begin
                    elapsed_q <= elapsed_q + 1'b1;
                    stable_q  <= stable_d;
                    // A settled ring wins over a timeout landing on the same cycle
                    if (stable_q == C_STABLE) begin
                        state_q <= S_SAMPLE;
                    end else if (elapsed_q == C_EL_LAST) begin
                        state_q  <= S_SAMPLE;
                        unstab_q <= 1'b1;
                    end
                end

                S_SAMPLE: begin
                    // Re-assert the ring reset whether we re-run or finish
                    puf_reset_q <= 1'b1;
`ifdef BR_MAJORITY_EN
                    ones_q <= ones_d;
                    eval_q <= eval_d;
                    if (eval_d < C_NEVAL) begin
                        state_q   <= S_RST;
                        rst_cnt_q <= '0;
                    end else begin
                        state_q        <= S_DONE;
                        rsp_bit_q      <= (ones_d > C_HALF);
                        rsp_ones_q     <= ones_d;
                        rsp_unstable_q <= unstab_q;
                    end
`else
                    state_q        <= S_DONE;
                    rsp_bit_q      <= synced;
                    rsp_unstable_q <= unstab_q;
`endif
                end

                S_DONE: begin
                    // Valid is raised one cycle into DONE and held until consumed
                    rsp_valid_q <= 1'b1;
                    if (rsp_valid_q && rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        ch_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_ready_o     = ch_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_bit_o      = rsp_bit_q;
    assign rsp_unstable_o = rsp_unstable_q;
    assign puf_reset_o    = puf_reset_q;
    assign puf_c_o        = puf_c_q;
    assign busy_o         = busy_q;

`ifdef BR_MAJORITY_EN
    assign rsp_ones_o = rsp_ones_q;
`else
    assign rsp_ones_o = '0;
`endif

endmodule

`default_nettype wire
